// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine feeding the Hi/Lo registers.
// Takes WIDTH+2 cycles per op, or 1 cycle for a divide by zero. A start while busy is dropped, not queued.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_SIGN  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DZERO = 3'd4;

  logic [2:0]         state;
  logic               op_r;
  logic               neg_main;
  logic               neg_rem;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   bmag;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // MULT: conditional add of |b| into the upper half, then shift {carry, acc} right.
  // DIV: acc holds {remainder, dividend/quotient}; shift left and trial-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-2:0], 1'b0};
    div_trial = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, bmag};
    if (!op_r)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    else
      acc_step = div_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_r     <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      bmag     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            neg_main <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem  <= a[WIDTH-1];
            cnt      <= CW'(WIDTH-1);
            acc      <= {{WIDTH{1'b0}}, a_mag};
            bmag     <= b_mag;
            state    <= (op && (b == '0)) ? S_DZERO : S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_SIGN;
        end
        S_SIGN: begin
          if (!op_r) begin
            {hi, lo} <= neg_main ? (~acc + 1'b1) : acc;
          end else begin
            lo <= neg_main ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            hi <= neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_DZERO: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign hi_write = done;
  assign lo_write = done;
  assign div_zero = (state == S_DZERO);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed checks of muldiv_sequencer: result values, cycle timing, divide by zero, ignored starts, reset abort.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         hi_write;
  logic         lo_write;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_write(hi_write), .lo_write(lo_write),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        inj;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered mid-cycle (after the negedge) of the cycle that carries start; returns at the
  // negedge of the first cycle after the op, so the next op can be issued back-to-back.
  task automatic run_op(input vec_t v, input int idx);
    int endc, done_cyc, dz_cyc, done_cnt, dz_cnt, wr_bad, busy_bad;
    logic [31:0] hs, ls;
    endc = v.dz ? 1 : W + 2;
    done_cyc = -1; dz_cyc = -1; done_cnt = 0; dz_cnt = 0; wr_bad = 0; busy_bad = 0;
    hs = 'x; ls = 'x;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    for (int c = 1; c <= endc + 1; c++) begin
      @(posedge clk); #1;
      if (v.inj && (c == 10 || c == W + 2)) begin
        start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd0;
      end else begin
        start = 1'b0; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      end
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (div_zero) begin
        dz_cnt++;
        if (dz_cyc < 0) dz_cyc = c;
      end
      if (hi_write !== done || lo_write !== done) wr_bad++;
      if (busy !== (c <= endc)) busy_bad++;
      if (c == endc) begin hs = hi; ls = lo; end
    end
    if (v.dz) begin
      chk($sformatf("v%0d div_zero_cycle", idx), 64'(dz_cyc), 64'd1);
      chk($sformatf("v%0d pulse_counts", idx), {32'(dz_cnt), 32'(done_cnt)}, {32'd1, 32'd0});
    end else begin
      chk($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(W + 2));
      chk($sformatf("v%0d pulse_counts", idx), {32'(dz_cnt), 32'(done_cnt)}, {32'd0, 32'd1});
    end
    chk($sformatf("v%0d write_pulses", idx), 64'(wr_bad), 64'd0);
    chk($sformatf("v%0d busy_profile", idx), 64'(busy_bad), 64'd0);
    chk($sformatf("v%0d hi_lo", idx), {hs, ls}, {v.hi, v.lo});
  endtask

  initial begin
    //            op    a              b              hi             lo             dz    inj
    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD,  32'hFFFFFFFF,  32'hFFFFFFEB,  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'd5,         32'd6,         32'd0,         32'd30,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'd9,         32'd0,         32'd0,         32'd30,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h80000000,  32'h80000000,  32'h40000000,  32'd0,         1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd1,         1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  32'hFFFFFFFA,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h80000000,  32'h80000000,  32'd0,         32'd1,         1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF,  32'h00000001,  1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {57'd0, busy, done, hi_write, lo_write, div_zero, 1'b0, 1'b0}, 64'd0);
    chk("reset_hi_lo", {hi, lo}, 64'd0);
    reset = 1'b0;

    // Back-to-back: vecs[0] injects starts in cycles 10 and 34, vecs[1] starts in cycle 35.
    for (int i = 0; i < NV; i++)
      run_op(vecs[i], i);

    // Abort a MULT with reset in cycle 15; hi/lo currently hold a nonzero result.
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFFFFFD;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 15) reset = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_flags", {60'd0, busy, done, div_zero, hi_write}, 64'd0);
    chk("abort_hi_lo", {hi, lo}, 64'd0);
    begin
      int dcnt;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done || busy) dcnt++;
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);
    end
    run_op(vecs[9], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
